// File: rtl/tsm_fourinput_allproducts_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tsm_fourinput_allproducts_accumulator
// Purpose  : Time-sharing-masking monomial accumulator for four-variable
//            S-box stages. Takes one share tuple (x,y,z,w) per beat for
//            NUM_SHARES beats. It keeps the four running share sums and all
//            eleven cross-monomials (xy .. xyzw). After the last share it
//            presents the 15 products with a valid/ready handshake.
// Ports    : clk, rst (sync, active-high)
//            in_valid/in_ready, x/y/z/w_share [WIDTH] : share beat input
//            flush        : drop partial tuple / pending result, go idle
//            share_idx    : index of next expected share
//            out_valid/out_ready, *_acc [WIDTH] : accumulated products
// Options  : TSM_ZERO_ON_IDLE_EN - force all *_acc outputs to 0 while
//            out_valid is low (internal registers unaffected)
// Revision : 1.0 - initial release
// ============================================================================
module tsm_fourinput_allproducts_accumulator #(
  parameter int NUM_SHARES = 3,
  parameter int WIDTH      = 1,
  parameter int IDXW       = $clog2(NUM_SHARES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_share,
  input  logic [WIDTH-1:0] y_share,
  input  logic [WIDTH-1:0] z_share,
  input  logic [WIDTH-1:0] w_share,
  input  logic             flush,
  output logic [IDXW-1:0]  share_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_acc,
  output logic [WIDTH-1:0] y_acc,
  output logic [WIDTH-1:0] z_acc,
  output logic [WIDTH-1:0] w_acc,
  output logic [WIDTH-1:0] xy_acc,
  output logic [WIDTH-1:0] xz_acc,
  output logic [WIDTH-1:0] xw_acc,
  output logic [WIDTH-1:0] yz_acc,
  output logic [WIDTH-1:0] yw_acc,
  output logic [WIDTH-1:0] zw_acc,
  output logic [WIDTH-1:0] xyz_acc,
  output logic [WIDTH-1:0] xyw_acc,
  output logic [WIDTH-1:0] xzw_acc,
  output logic [WIDTH-1:0] yzw_acc,
  output logic [WIDTH-1:0] xyzw_acc
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NUM_SHARES - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] share_idx_q, share_idx_d;

  // Monomials are indexed by a 4-bit variable-set mask:
  // bit0 = x, bit1 = y, bit2 = z, bit3 = w (e.g. 5 = xz, 15 = xyzw).
  logic [WIDTH-1:0] mono_q [1:15];
  logic [WIDTH-1:0] mono_d [1:15];

  logic [WIDTH-1:0] w_share_v [0:3];
  logic [WIDTH-1:0] w_prod    [0:15];   // AND of incoming shares over mask
  logic [WIDTH-1:0] w_mono    [0:15];   // registered monomials, M_empty = 1
  logic             w_beat;

  assign w_share_v[0] = x_share;
  assign w_share_v[1] = y_share;
  assign w_share_v[2] = z_share;
  assign w_share_v[3] = w_share;

  assign in_ready  = (state_q != ST_DONE);
  assign out_valid = (state_q == ST_DONE);
  assign share_idx = share_idx_q;
  assign w_beat    = in_valid && in_ready;

  always_comb begin : comb_products
    for (int t = 0; t < 16; t++) begin
      w_prod[t] = (t[0] ? w_share_v[0] : {WIDTH{1'b1}})
                & (t[1] ? w_share_v[1] : {WIDTH{1'b1}})
                & (t[2] ? w_share_v[2] : {WIDTH{1'b1}})
                & (t[3] ? w_share_v[3] : {WIDTH{1'b1}});
    end
    w_mono[0] = {WIDTH{1'b1}};
    for (int s = 1; s < 16; s++) begin
      w_mono[s] = mono_q[s];
    end
  end

  always_comb begin : comb_next
    state_d     = state_q;
    share_idx_d = share_idx_q;
    for (int s = 1; s < 16; s++) begin
      mono_d[s] = mono_q[s];
    end

    if (flush) begin
      state_d     = ST_IDLE;
      share_idx_d = '0;
      for (int s = 1; s < 16; s++) begin
        mono_d[s] = '0;
      end
    end else if (state_q == ST_DONE) begin
      if (out_ready) begin
        state_d = ST_IDLE;
      end
    end else if (w_beat) begin
      if (share_idx_q == C_LAST_IDX) begin
        state_d     = ST_DONE;
        share_idx_d = '0;
      end else begin
        state_d     = ST_ACCUM;
        share_idx_d = share_idx_q + 1'b1;
      end

      for (int s = 1; s < 16; s++) begin
        if (share_idx_q == '0) begin
          // First share: previous results are irrelevant, load fresh products.
          mono_d[s] = w_prod[s];
        end else begin
          // Expand prod_v (A_v ^ s_v) over every subset T of S moved to the
          // new share; the complementary subset comes from the old monomial.
          mono_d[s] = '0;
          for (int t = 0; t < 16; t++) begin
            if ((t & ~s) == 0) begin
              mono_d[s] = mono_d[s] ^ (w_mono[s & ~t] & w_prod[t]);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      share_idx_q <= '0;
      for (int s = 1; s < 16; s++) begin
        mono_q[s] <= '0;
      end
    end else begin
      state_q     <= state_d;
      share_idx_q <= share_idx_d;
      for (int s = 1; s < 16; s++) begin
        mono_q[s] <= mono_d[s];
      end
    end
  end

  logic [WIDTH-1:0] w_out_mask;
`ifdef TSM_ZERO_ON_IDLE_EN
  assign w_out_mask = {WIDTH{out_valid}};
`else
  assign w_out_mask = {WIDTH{1'b1}};
`endif

  assign x_acc    = mono_q[1]  & w_out_mask;
  assign y_acc    = mono_q[2]  & w_out_mask;
  assign z_acc    = mono_q[4]  & w_out_mask;
  assign w_acc    = mono_q[8]  & w_out_mask;
  assign xy_acc   = mono_q[3]  & w_out_mask;
  assign xz_acc   = mono_q[5]  & w_out_mask;
  assign xw_acc   = mono_q[9]  & w_out_mask;
  assign yz_acc   = mono_q[6]  & w_out_mask;
  assign yw_acc   = mono_q[10] & w_out_mask;
  assign zw_acc   = mono_q[12] & w_out_mask;
  assign xyz_acc  = mono_q[7]  & w_out_mask;
  assign xyw_acc  = mono_q[11] & w_out_mask;
  assign xzw_acc  = mono_q[13] & w_out_mask;
  assign yzw_acc  = mono_q[14] & w_out_mask;
  assign xyzw_acc = mono_q[15] & w_out_mask;

endmodule
`default_nettype wire
